// File: rtl/message_build_arbiter.sv
// Whole-message arbiter sharing one message_build between NUM_REQ requesters,
// with an ID FIFO tagging message order. Define MSG_ARB_FIXED_PRIO_EN for fixed priority.
module message_build_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ID_W          = $clog2(NUM_REQ),
    parameter int ID_FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NUM_REQ*64-1:0]    req_cfg_size,
    input  logic [NUM_REQ*2-1:0]     req_cfg_scheme,
    input  logic [NUM_REQ-1:0]       req_cfg_last,
    input  logic [NUM_REQ-1:0]       req_cfg_valid,
    output logic [NUM_REQ-1:0]       req_cfg_ready,
    input  logic [NUM_REQ*512-1:0]   req_data_in,
    input  logic [NUM_REQ-1:0]       req_data_in_last,
    input  logic [NUM_REQ-1:0]       req_data_in_valid,
    output logic [NUM_REQ-1:0]       req_data_in_ready,
    output logic [63:0]              mb_cfg_size,
    output logic [1:0]               mb_cfg_scheme,
    output logic                     mb_cfg_last,
    output logic                     mb_cfg_valid,
    input  logic                     mb_cfg_ready,
    output logic [511:0]             mb_data_in,
    output logic                     mb_data_in_last,
    output logic                     mb_data_in_valid,
    input  logic                     mb_data_in_ready,
    output logic [ID_W-1:0]          id_out,
    output logic                     id_out_valid,
    input  logic                     id_out_ready
);

    localparam int PTR_W = $clog2(ID_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(ID_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        DATA
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] grant_nxt;
    logic [ID_W-1:0] winner;
    logic            any_valid;
    logic            cfg_fire;
    logic            data_last_fire;
    logic            push;
    logic            pop;

    logic [ID_W-1:0]  fifo_mem [ID_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

`ifdef MSG_ARB_FIXED_PRIO_EN
    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_cfg_valid[i]) begin
                winner    = ID_W'(i);
                any_valid = 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && req_cfg_valid[idx]) begin
                winner    = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rr_ptr <= '0;
        end else if (data_last_fire) begin
            rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
        end
    end
`endif

    assign cfg_fire       = (state == CFG) && mb_cfg_valid && mb_cfg_ready;
    assign data_last_fire = (state == DATA) && mb_data_in_valid && mb_data_in_ready
                            && mb_data_in_last;
    assign push           = cfg_fire;
    assign pop            = (count != '0) && id_out_ready;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (any_valid && (count < FIFO_FULL)) begin
                    grant_nxt = winner;
                    state_nxt = CFG;
                end
            end
            CFG: begin
                if (cfg_fire) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (data_last_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only the owner's channel for the current phase is connected; everything else reads zero.
    always_comb begin
        mb_cfg_size       = '0;
        mb_cfg_scheme     = '0;
        mb_cfg_last       = 1'b0;
        mb_cfg_valid      = 1'b0;
        mb_data_in        = '0;
        mb_data_in_last   = 1'b0;
        mb_data_in_valid  = 1'b0;
        req_cfg_ready     = '0;
        req_data_in_ready = '0;
        case (state)
            CFG: begin
                mb_cfg_size          = req_cfg_size[int'(grant)*64 +: 64];
                mb_cfg_scheme        = req_cfg_scheme[int'(grant)*2 +: 2];
                mb_cfg_last          = req_cfg_last[grant];
                mb_cfg_valid         = req_cfg_valid[grant];
                req_cfg_ready[grant] = mb_cfg_ready;
            end
            DATA: begin
                mb_data_in               = req_data_in[int'(grant)*512 +: 512];
                mb_data_in_last          = req_data_in_last[grant];
                mb_data_in_valid         = req_data_in_valid[grant];
                req_data_in_ready[grant] = mb_data_in_ready;
            end
            default: begin
            end
        endcase
    end

    // Count only drops between grant and push, so a push never finds the FIFO full.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < ID_FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= grant;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign id_out       = fifo_mem[rd_ptr];
    assign id_out_valid = (count != '0);

endmodule

// File: tb/tb_message_build_arbiter.sv
// Directed self-checking bench for message_build_arbiter (NUM_REQ=2, ID_FIFO_DEPTH=4).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_message_build_arbiter;

    logic            clk;
    logic            nrst;
    logic [127:0]    req_cfg_size;
    logic [3:0]      req_cfg_scheme;
    logic [1:0]      req_cfg_last;
    logic [1:0]      req_cfg_valid;
    logic [1:0]      req_cfg_ready;
    logic [1023:0]   req_data_in;
    logic [1:0]      req_data_in_last;
    logic [1:0]      req_data_in_valid;
    logic [1:0]      req_data_in_ready;
    logic [63:0]     mb_cfg_size;
    logic [1:0]      mb_cfg_scheme;
    logic            mb_cfg_last;
    logic            mb_cfg_valid;
    logic            mb_cfg_ready;
    logic [511:0]    mb_data_in;
    logic            mb_data_in_last;
    logic            mb_data_in_valid;
    logic            mb_data_in_ready;
    logic [0:0]      id_out;
    logic            id_out_valid;
    logic            id_out_ready;

    int checks;
    int failures;

    message_build_arbiter #(
        .NUM_REQ       (2),
        .ID_W          (1),
        .ID_FIFO_DEPTH (4)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .req_cfg_size      (req_cfg_size),
        .req_cfg_scheme    (req_cfg_scheme),
        .req_cfg_last      (req_cfg_last),
        .req_cfg_valid     (req_cfg_valid),
        .req_cfg_ready     (req_cfg_ready),
        .req_data_in       (req_data_in),
        .req_data_in_last  (req_data_in_last),
        .req_data_in_valid (req_data_in_valid),
        .req_data_in_ready (req_data_in_ready),
        .mb_cfg_size       (mb_cfg_size),
        .mb_cfg_scheme     (mb_cfg_scheme),
        .mb_cfg_last       (mb_cfg_last),
        .mb_cfg_valid      (mb_cfg_valid),
        .mb_cfg_ready      (mb_cfg_ready),
        .mb_data_in        (mb_data_in),
        .mb_data_in_last   (mb_data_in_last),
        .mb_data_in_valid  (mb_data_in_valid),
        .mb_data_in_ready  (mb_data_in_ready),
        .id_out            (id_out),
        .id_out_valid      (id_out_valid),
        .id_out_ready      (id_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [511:0] mk_data(input int r, input int m, input int b);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(r * 256 + m * 16 + b);
        return {16{w}};
    endfunction

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_cfg_size      = '0;
        req_cfg_scheme    = '0;
        req_cfg_last      = '0;
        req_cfg_valid     = '0;
        req_data_in       = '0;
        req_data_in_last  = '0;
        req_data_in_valid = '0;
        mb_cfg_ready      = 1'b1;
        mb_data_in_ready  = 1'b1;
        id_out_ready      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        clear_inputs();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst              = 1'b0;
        clear_inputs();
        req_cfg_valid     = 2'b11;
        req_data_in_valid = 2'b11;
        req_data_in       = {mk_data(1, 0, 0), mk_data(0, 0, 0)};
        id_out_ready      = 1'b1;
        repeat (2) next_cycle();
        #1;
        checks++;
        if ({req_cfg_ready, req_data_in_ready} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_readys got=%b exp=0000", {req_cfg_ready, req_data_in_ready});
        end
        checks++;
        if ({mb_cfg_valid, mb_data_in_valid, id_out_valid} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_valids got=%b exp=000", {mb_cfg_valid, mb_data_in_valid, id_out_valid});
        end
        checks++;
        if (mb_data_in !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h exp=0", mb_data_in);
        end
        next_cycle();
        nrst = 1'b1;
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        req_cfg_size[63:0]  = 64'h200;
        req_cfg_scheme[1:0] = 2'd0;
        req_cfg_last[0]     = 1'b1;
        req_cfg_valid       = 2'b01;
        #1;
        checks++;
        if (mb_cfg_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_idle_cfg_valid got=%b exp=0", mb_cfg_valid);
        end
        next_cycle();
        #1;
        checks++;
        if ({mb_cfg_valid, mb_cfg_last, req_cfg_ready} !== 4'b1101) begin
            failures++;
            $display("[TB] FAIL single_cfg got=%b exp=1101", {mb_cfg_valid, mb_cfg_last, req_cfg_ready});
        end
        checks++;
        if ({mb_cfg_size, mb_cfg_scheme} !== {64'h200, 2'd0}) begin
            failures++;
            $display("[TB] FAIL single_cfg_size got=%h/%0d exp=200/0", mb_cfg_size, mb_cfg_scheme);
        end
        next_cycle();
        req_cfg_valid        = 2'b00;
        req_data_in[511:0]   = mk_data(0, 0, 0);
        req_data_in_last     = 2'b01;
        req_data_in_valid    = 2'b01;
        #1;
        checks++;
        if (mb_data_in !== mk_data(0, 0, 0)) begin
            failures++;
            $display("[TB] FAIL single_data got=%h exp=%h", mb_data_in, mk_data(0, 0, 0));
        end
        checks++;
        if ({mb_data_in_valid, mb_data_in_last, req_data_in_ready, mb_cfg_valid} !== 5'b11010) begin
            failures++;
            $display("[TB] FAIL single_data_ctl got=%b exp=11010",
                     {mb_data_in_valid, mb_data_in_last, req_data_in_ready, mb_cfg_valid});
        end
        checks++;
        if ({id_out_valid, id_out} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL single_id got=%b exp=10", {id_out_valid, id_out});
        end
        next_cycle();
        req_data_in_valid = 2'b00;
        id_out_ready      = 1'b1;
        #1;
        checks++;
        if ({req_data_in_ready, mb_data_in_valid, id_out_valid} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL single_done got=%b exp=0001", {req_data_in_ready, mb_data_in_valid, id_out_valid});
        end
        next_cycle();
        id_out_ready = 1'b0;
        #1;
        checks++;
        if (id_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_pop got=%b exp=0", id_out_valid);
        end
    endtask

    task automatic test_contention();
        int nmsg [2];
        int exp_id [4];
        int e;
        nmsg[0] = 0;
        nmsg[1] = 0;
        do_reset();
        req_cfg_size      = {64'h101, 64'h100};
        req_cfg_scheme    = {2'd2, 2'd1};
        req_cfg_last      = 2'b11;
        req_cfg_valid     = 2'b11;
        req_data_in_valid = 2'b11;
        req_data_in       = {mk_data(1, 0, 0), mk_data(0, 0, 0)};
        for (int m = 0; m < 4; m++) begin
`ifdef MSG_ARB_FIXED_PRIO_EN
            e = 0;
`else
            e = m % 2;
`endif
            exp_id[m] = e;
            #1;
            checks++;
            if ({req_cfg_ready, mb_cfg_valid} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL cont_idle msg=%0d got=%b exp=000", m, {req_cfg_ready, mb_cfg_valid});
            end
            next_cycle();
            #1;
            checks++;
            if (req_cfg_ready !== (2'b01 << e) || mb_cfg_size !== (e == 1 ? 64'h101 : 64'h100)) begin
                failures++;
                $display("[TB] FAIL cont_grant msg=%0d got=%b/%h exp_owner=%0d", m, req_cfg_ready, mb_cfg_size, e);
            end
            next_cycle();
            for (int b = 0; b < 2; b++) begin
                req_data_in[e*512 +: 512] = mk_data(e, nmsg[e], b);
                req_data_in_last[e]       = (b == 1);
                #1;
                checks++;
                if (req_data_in_ready !== (2'b01 << e) || req_cfg_ready !== 2'b00 ||
                    mb_data_in !== mk_data(e, nmsg[e], b) || mb_data_in_last !== (b == 1)) begin
                    failures++;
                    $display("[TB] FAIL cont_beat msg=%0d beat=%0d got_rdy=%b got_last=%b got=%h exp_owner=%0d",
                             m, b, req_data_in_ready, mb_data_in_last, mb_data_in, e);
                end
                next_cycle();
            end
            nmsg[e]++;
        end
        req_cfg_valid     = 2'b00;
        req_data_in_valid = 2'b00;
        id_out_ready      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (id_out_valid !== 1'b1 || id_out !== 1'(exp_id[k])) begin
                failures++;
                $display("[TB] FAIL cont_fifo entry=%0d got=%b/%0d exp=1/%0d", k, id_out_valid, id_out, exp_id[k]);
            end
            next_cycle();
        end
        id_out_ready  = 1'b0;
        req_cfg_valid = 2'b10;
        #1;
        checks++;
        if (id_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cont_fifo_empty got=%b exp=0", id_out_valid);
        end
        next_cycle();
        #1;
        checks++;
        if (req_cfg_ready !== 2'b10) begin
            failures++;
            $display("[TB] FAIL cont_req1_alone got=%b exp=10", req_cfg_ready);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        id_out_ready        = 1'b0;
        req_cfg_size[63:0]  = 64'h300;
        req_cfg_last        = 2'b01;
        req_cfg_valid       = 2'b01;
        req_data_in[511:0]  = mk_data(0, 9, 0);
        req_data_in_last    = 2'b01;
        req_data_in_valid   = 2'b01;
        for (int m = 0; m < 4; m++) begin
            #1;
            checks++;
            if (mb_cfg_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL full_idle msg=%0d got=%b exp=0", m, mb_cfg_valid);
            end
            next_cycle();
            #1;
            checks++;
            if (req_cfg_ready !== 2'b01) begin
                failures++;
                $display("[TB] FAIL full_cfg msg=%0d got=%b exp=01", m, req_cfg_ready);
            end
            next_cycle();
            #1;
            checks++;
            if (req_data_in_ready !== 2'b01) begin
                failures++;
                $display("[TB] FAIL full_data msg=%0d got=%b exp=01", m, req_data_in_ready);
            end
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({req_cfg_ready, mb_cfg_valid, id_out_valid} !== 4'b0001) begin
                failures++;
                $display("[TB] FAIL full_blocked cyc=%0d got=%b exp=0001", k, {req_cfg_ready, mb_cfg_valid, id_out_valid});
            end
            next_cycle();
        end
        id_out_ready = 1'b1;
        #1;
        checks++;
        if ({req_cfg_ready, mb_cfg_valid, id_out_valid, id_out} !== 5'b00010) begin
            failures++;
            $display("[TB] FAIL full_pop got=%b exp=00010", {req_cfg_ready, mb_cfg_valid, id_out_valid, id_out});
        end
        next_cycle();
        id_out_ready = 1'b0;
        #1;
        checks++;
        if (mb_cfg_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_arb_cycle got=%b exp=0", mb_cfg_valid);
        end
        next_cycle();
        #1;
        checks++;
        if ({mb_cfg_valid, req_cfg_ready} !== 3'b101) begin
            failures++;
            $display("[TB] FAIL full_fifth_grant got=%b exp=101", {mb_cfg_valid, req_cfg_ready});
        end
    endtask

    task automatic test_backpressure();
        int  beat;
        logic rdy;
        do_reset();
        mb_cfg_ready          = 1'b0;
        req_cfg_size[127:64]  = 64'h555;
        req_cfg_scheme[3:2]   = 2'd3;
        req_cfg_last          = 2'b10;
        req_cfg_valid         = 2'b10;
        req_data_in[511:0]    = mk_data(0, 7, 0);
        req_data_in_valid     = 2'b01;
        #1;
        checks++;
        if ({req_cfg_ready, mb_cfg_valid} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL bp_idle got=%b exp=000", {req_cfg_ready, mb_cfg_valid});
        end
        next_cycle();
        #1;
        checks++;
        if ({mb_cfg_valid, req_cfg_ready} !== 3'b100 || mb_cfg_scheme !== 2'd3) begin
            failures++;
            $display("[TB] FAIL bp_cfg_stall got=%b scheme=%0d exp=100/3", {mb_cfg_valid, req_cfg_ready}, mb_cfg_scheme);
        end
        next_cycle();
        mb_cfg_ready = 1'b1;
        #1;
        checks++;
        if ({mb_cfg_valid, req_cfg_ready, req_data_in_ready} !== 5'b11000 || mb_cfg_size !== 64'h555) begin
            failures++;
            $display("[TB] FAIL bp_cfg got=%b size=%h exp=11000/555",
                     {mb_cfg_valid, req_cfg_ready, req_data_in_ready}, mb_cfg_size);
        end
        next_cycle();
        req_cfg_valid     = 2'b00;
        req_data_in_valid = 2'b11;
        beat              = 0;
        for (int c = 0; c < 5; c++) begin
            rdy                     = ((c % 2) == 0);
            mb_data_in_ready        = rdy;
            req_data_in[1023:512]   = mk_data(1, 0, beat);
            req_data_in_last[1]     = (beat == 2);
            #1;
            checks++;
            if (req_data_in_ready !== {rdy, 1'b0} || mb_data_in_valid !== 1'b1 ||
                mb_data_in !== mk_data(1, 0, beat) || mb_data_in_last !== (beat == 2)) begin
                failures++;
                $display("[TB] FAIL bp_beat cyc=%0d got_rdy=%b got_valid=%b got=%h exp_rdy=%b exp_beat=%0d",
                         c, req_data_in_ready, mb_data_in_valid, mb_data_in, {rdy, 1'b0}, beat);
            end
            next_cycle();
            if (rdy) beat++;
        end
        mb_data_in_ready = 1'b1;
        #1;
        checks++;
        if ({req_data_in_ready, mb_data_in_valid, id_out_valid, id_out} !== 5'b00011) begin
            failures++;
            $display("[TB] FAIL bp_done got=%b exp=00011", {req_data_in_ready, mb_data_in_valid, id_out_valid, id_out});
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_cfg_valid      = 2'b01;
        req_cfg_last       = 2'b11;
        req_data_in[511:0] = mk_data(0, 1, 0);
        req_data_in_last   = 2'b01;
        req_data_in_valid  = 2'b01;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (req_data_in_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL mid_first_msg got=%b exp=01", req_data_in_ready);
        end
        next_cycle();
        req_cfg_valid         = 2'b10;
        req_data_in_valid     = 2'b10;
        req_data_in_last      = 2'b00;
        req_data_in[1023:512] = mk_data(1, 1, 0);
        next_cycle();
        #1;
        checks++;
        if (req_cfg_ready !== 2'b10) begin
            failures++;
            $display("[TB] FAIL mid_cfg got=%b exp=10", req_cfg_ready);
        end
        next_cycle();
        #1;
        checks++;
        if (req_data_in_ready !== 2'b10) begin
            failures++;
            $display("[TB] FAIL mid_beat1 got=%b exp=10", req_data_in_ready);
        end
        next_cycle();
        req_data_in[1023:512] = mk_data(1, 1, 1);
        nrst                  = 1'b0;
        next_cycle();
        nrst              = 1'b1;
        req_cfg_valid     = 2'b11;
        req_data_in_valid = 2'b00;
        #1;
        checks++;
        if ({req_cfg_ready, req_data_in_ready, mb_data_in_valid, mb_cfg_valid, id_out_valid} !== 7'b0000000) begin
            failures++;
            $display("[TB] FAIL mid_after_reset got=%b exp=0000000",
                     {req_cfg_ready, req_data_in_ready, mb_data_in_valid, mb_cfg_valid, id_out_valid});
        end
        next_cycle();
        #1;
        checks++;
        if (req_cfg_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL mid_rr_restart got=%b exp=01", req_cfg_ready);
        end
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nrst     = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_fifo_full();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/message_build_arbiter.md
Name: message_build_arbiter

Overview:
- Shares one message_build instance between NUM_REQ independent requesters.
- Each requester offers a cfg stream (size/scheme/last) and a 512-bit data_in stream.
- Arbitrates at whole-message granularity: one requester owns message_build from its cfg handshake until its data_in_last handshake.
- Pushes the granted requester index into an ID FIFO so downstream hash logic can tag the resulting message blocks.

Parameters:
- NUM_REQ, 2: number of requesters (≥2).
- ID_W, $clog2(NUM_REQ): width of requester index.
- ID_FIFO_DEPTH, 4: ID FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all logic on posedge.
- nrst  in  1  reset, synchronous, active-low.
- req_cfg_size  in  NUM_REQ*64  per-requester cfg_size; requester i at [i*64 +: 64].
- req_cfg_scheme  in  NUM_REQ*2  per-requester cfg_scheme.
- req_cfg_last  in  NUM_REQ  per-requester cfg_last.
- req_cfg_valid  in  NUM_REQ  per-requester cfg valid.
- req_cfg_ready  out  NUM_REQ  per-requester cfg ready.
- req_data_in  in  NUM_REQ*512  per-requester data beat.
- req_data_in_last  in  NUM_REQ  last beat of message.
- req_data_in_valid  in  NUM_REQ  data valid.
- req_data_in_ready  out  NUM_REQ  data ready.
- mb_cfg_size  out  64  to message_build cfg_size.
- mb_cfg_scheme  out  2  to message_build cfg_scheme.
- mb_cfg_last  out  1  to message_build cfg_last.
- mb_cfg_valid  out  1  to message_build cfg_valid.
- mb_cfg_ready  in  1  from message_build cfg_ready.
- mb_data_in  out  512  to message_build data_in.
- mb_data_in_last  out  1  to message_build data_in_last.
- mb_data_in_valid  out  1  to message_build data_in_valid.
- mb_data_in_ready  in  1  from message_build data_in_ready.
- id_out  out  ID_W  FIFO head: requester owning the oldest unconsumed message.
- id_out_valid  out  1  ID FIFO non-empty.
- id_out_ready  in  1  downstream pops ID.

Behaviour:
- Reset (nrst low at posedge):
  - state=IDLE, grant=0, rr_ptr=0, FIFO emptied (count=0).
  - All ready/valid outputs 0; data outputs are don't-care but driven 0 while not granted.
- States:
  - IDLE: if any req_cfg_valid and FIFO count<ID_FIFO_DEPTH, pick the winner round-robin, searching from rr_ptr upward with wrap. Register grant=winner; next state CFG. Otherwise stay in IDLE. All req ready=0, mb valids=0.
  - CFG: mb_cfg_* and mb_cfg_valid = requester[grant] fields; req_cfg_ready[grant]=mb_cfg_ready; other readys 0.
    - On handshake (mb_cfg_valid & mb_cfg_ready): push grant into FIFO; next state DATA.
  - DATA: mb_data_in* = requester[grant]; req_data_in_ready[grant]=mb_data_in_ready; others 0.
    - On handshake with last=1: rr_ptr=(grant+1) mod NUM_REQ; next state IDLE.
- Timing:
  - Pass-through is combinational, zero latency.
  - Arbitration costs exactly 1 cycle (IDLE→CFG) per message.
  - No cfg passes in DATA, no data passes in CFG/IDLE.
- Non-granted requesters stall with ready=0 and must hold their valid.
- A requester dropping cfg_valid in CFG stalls the arbiter; no re-arbitration until its message completes.
- ID FIFO:
  - Pop on id_out_valid & id_out_ready.
  - Push and pop in the same cycle: count unchanged.
  - Pop when empty is ignored.
  - Full only blocks new grants in IDLE. A push can never overflow, because count only falls between grant and push.
  - Pointers wrap mod ID_FIFO_DEPTH.
- Reset mid-message: sync reset aborts immediately; the partial message is abandoned, and message_build must be reset alongside.

Optional Feature:
- MSG_ARB_FIXED_PRIO_EN
  - Defined: IDLE picks the lowest-index requester with cfg_valid; rr_ptr is not updated and not used.
  - Undefined: round-robin as above.

Test Plan:
- Single requester, NUM_REQ=2:
  - Stimulus: req0 sends cfg (size=64'h200, scheme=0, last=1) and 1 data beat, last=1.
  - Response: mb_cfg_valid rises 1 cycle after req_cfg_valid[0]; data passes unchanged; id_out=0, valid=1.
- Contention, round-robin:
  - Stimulus: both requesters valid continuously, 2 messages each, 2 beats each.
  - Response: grant order 0,1,0,1; no beat interleaving; ID FIFO holds 0,1,0,1.
- FIFO full:
  - Stimulus: id_out_ready=0, req0 sends 5 messages.
  - Response: only 4 grants; state stays IDLE with req_cfg_ready=0. One pop, then 5th grant 1 cycle later.
- Backpressure:
  - Stimulus: mb_data_in_ready toggles 1/0 during a 3-beat message from req1.
  - Response: req_data_in_ready[1] mirrors it; req0 readys stay 0; state returns to IDLE only after beat 3 handshake.
- Reset mid-DATA:
  - Stimulus: nrst low for 1 cycle after beat 1 of 3.
  - Response: next cycle state IDLE, id_out_valid=0, all readys 0, rr_ptr=0.
- MSG_ARB_FIXED_PRIO_EN defined:
  - Stimulus: both requesters continuously valid.
  - Response: req0 wins every grant; req1 starves until req0 deasserts cfg_valid.
